gate_tt_driver: RTL and testbench
=================================

GATE_TT_DRIVER -- requirements
Module: gate_tt_driver

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, setting the wait cycles per input combination before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a run request, sampled in IDLE only.
REQ-005 SHALL have port expected, input, 4, the expected gate output per combination; bit i is the expected s for {a,b}=i, captured on start.
REQ-006 SHALL have ports a and b, output, 1 each, driving the two-input gate under test.
REQ-007 SHALL have port s, input, 1, the output of the gate under test.
REQ-008 SHALL have port busy, output, 1, high from the cycle after start acceptance until done.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse at run completion.
REQ-010 SHALL have port pass, output, 1, high when all four samples matched; valid from done and held until the next accepted start.
REQ-011 SHALL have port fail_idx, output, 2, the index of the first mismatching combination; 0 when pass=1.
REQ-012 SHALL have port obs_tt, output, 4, the observed truth table; bit i is the s sampled for {a,b}=i.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-014 SHALL go IDLE->APPLY on start=1, register expected, clear pass/fail_idx/obs_tt, and set the combination index to 0.
REQ-015 SHALL drive {a,b}=index from the APPLY entry cycle and hold it through SAMPLE.
REQ-016 SHALL stay in APPLY for exactly SETTLE_CYCLES cycles, then spend 1 cycle in SAMPLE, where s is registered and compared at the closing edge.
REQ-017 SHALL go SAMPLE->APPLY with index+1 when index<3, and SAMPLE->DONE when index=3; the index SHALL NOT wrap past 3.
REQ-018 SHALL record fail_idx only for the first mismatch; later mismatches leave it unchanged.
REQ-019 SHALL assert done and the final pass for exactly the one DONE cycle, 4*(SETTLE_CYCLES+1)+1 edges after the edge that accepted start, then return to IDLE.
REQ-020 SHALL return {a,b}=00 in IDLE and DONE.
REQ-021 SHALL ignore start while busy; start held high through DONE SHALL begin a new run on the cycle after DONE.
REQ-022 SHALL treat s as synchronous to clk, with no synchronizer.

Reset
REQ-023 SHALL force, while rst_n=0 and regardless of clk: state IDLE, index 0, a=b=0, busy=0, done=0, pass=0, fail_idx=0, obs_tt=0, registered expected=0.
REQ-024 SHALL abandon a run on reset mid-run, with no done pulse; the next start runs a full fresh sequence.

Configuration
REQ-025 SHALL, with GATE_TT_CAPTURE_EN defined, update obs_tt bit index at each SAMPLE edge.
REQ-026 SHALL, with GATE_TT_CAPTURE_EN undefined, tie obs_tt to 0 and infer no capture registers; pass/fail_idx behaviour SHALL be unchanged.

Structure
REQ-027 SHALL place in shared package gate_tt_pkg: the state enum typedef, constant NUM_COMBOS=4, and index width constant IDX_W=2.
REQ-028 SHALL implement the settle counter as sub-module gate_tt_settle_cnt (load on APPLY entry, terminal-count flag).

Verification
REQ-029 SHALL cover: NAND model DUT, expected=4'b0111, SETTLE_CYCLES=1, start pulse -> done 9 edges later, pass=1, fail_idx=0, obs_tt=4'b0111 (macro on).
REQ-030 SHALL cover: AND model DUT, expected=4'b0111 -> pass=0, fail_idx=0, obs_tt=4'b1000.
REQ-031 SHALL cover: DUT correct except idx 2, expected=4'b0111 -> pass=0, fail_idx=2.
REQ-032 SHALL cover: a second start pulse mid-run -> ignored, exactly one done pulse; start held high -> back-to-back runs, each done 9 edges apart +1 DONE cycle.
REQ-033 SHALL cover: rst_n low during SAMPLE of idx 1 -> all outputs 0 immediately, no done; restart -> full pass.
REQ-034 SHALL cover: SETTLE_CYCLES=3 with a DUT delayed 3 cycles -> pass=1, done after 17 edges; macro off -> obs_tt stays 0.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// Shared definitions for the two-input gate truth-table driver.
//   state_t    : controller states (IDLE, APPLY, SAMPLE, DONE)
//   NUM_COMBOS : number of input combinations of a two-input gate
//   IDX_W      : width of the combination index
package gate_tt_pkg;

  localparam int NUM_COMBOS = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_tt_settle_cnt.sv
// Settle-time down-counter for the gate truth-table driver.
// Loaded with SETTLE_CYCLES-1 on the edge that enters APPLY, then counts
// down to zero and holds there; tc is high while the count is zero, so
// APPLY lasts exactly SETTLE_CYCLES cycles.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   load  : reload the counter (asserted on the edge entering APPLY)
//   tc    : terminal count reached
module gate_tt_settle_cnt #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/gate_tt_driver.sv
// Truth-table driver for a two-input gate under test.
// On start it walks {a,b} through 00,01,10,11, waits SETTLE_CYCLES (1..15)
// per combination, samples s and compares it with the captured expected
// table. Reports pass, the first failing index and (optionally) the
// observed truth table.
// Optional feature: define GATE_TT_CAPTURE_EN to capture obs_tt; otherwise
// obs_tt is tied to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : run request (accepted in IDLE only)
//   expected   : expected s per combination, bit i for {a,b}=i
//   a, b       : drive to the gate under test
//   s          : gate output (synchronous to clk)
//   busy       : run in progress (APPLY/SAMPLE)
//   done       : one-cycle completion pulse
//   pass       : all four samples matched, held until next start
//   fail_idx   : first mismatching combination, 0 on pass
//   obs_tt     : observed truth table
//
// state  | meaning
// IDLE   | waiting for start, {a,b}=00
// APPLY  | driving {a,b}=index, settling for SETTLE_CYCLES cycles
// SAMPLE | s compared and recorded at the closing edge
// DONE   | one-cycle done pulse, {a,b}=00
module gate_tt_driver
  import gate_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_COMBOS-1:0] expected,
  output logic                  a,
  output logic                  b,
  input  logic                  s,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [NUM_COMBOS-1:0] obs_tt
);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [NUM_COMBOS-1:0] exp_q;
  logic                  mism_seen;
  logic                  load;
  logic                  tc;
  logic                  last;
  logic                  match;

  assign last  = (idx == IDX_W'(NUM_COMBOS - 1));
  assign match = (s == exp_q[idx]);

  gate_tt_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = APPLY;
          load      = 1'b1;
        end
      end
      APPLY: begin
        if (tc) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = APPLY;
          load      = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      exp_q     <= '0;
      pass      <= 1'b0;
      fail_idx  <= '0;
      mism_seen <= 1'b0;
    end else if (state == IDLE && start) begin
      idx       <= '0;
      exp_q     <= expected;
      pass      <= 1'b0;
      fail_idx  <= '0;
      mism_seen <= 1'b0;
    end else if (state == SAMPLE) begin
      if (!match && !mism_seen) begin
        fail_idx  <= idx;
        mism_seen <= 1'b1;
      end
      // Index stops at the last combination instead of wrapping.
      if (last) begin
        pass <= match && !mism_seen;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef GATE_TT_CAPTURE_EN
  logic [NUM_COMBOS-1:0] obs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_q <= '0;
    end else if (state == IDLE && start) begin
      obs_q <= '0;
    end else if (state == SAMPLE) begin
      obs_q[idx] <= s;
    end
  end

  assign obs_tt = obs_q;
`else
  assign obs_tt = '0;
`endif

  assign busy   = (state == APPLY) || (state == SAMPLE);
  assign done   = (state == DONE);
  assign {a, b} = busy ? idx : 2'b00;

endmodule

// File: tb/tb_gate_tt_driver.sv
// Scoreboard bench for gate_tt_driver: u0 (SETTLE_CYCLES=1) drives a
// combinational gate model, u1 (SETTLE_CYCLES=3) drives a gate model
// delayed by three cycles. Expected results come from the truth-table
// comparison rules and are checked when done is seen.
module tb_gate_tt_driver;

`ifdef GATE_TT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  typedef struct {
    logic       pass;
    logic [1:0] fi;
    logic [3:0] obs;
    int         accept;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  logic       start0, a0, b0, s0, busy0, done0, pass0;
  logic [3:0] exp0, tt0, obs0;
  logic [1:0] fi0;
  logic       start1, a1, b1, s1, busy1, done1, pass1;
  logic [3:0] exp1, tt1, obs1;
  logic [1:0] fi1;
  logic [2:0] pipe1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last0;
  exp_t last1;

  gate_tt_driver #(.SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0),
    .a(a0), .b(b0), .s(s0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_idx(fi0), .obs_tt(obs0)
  );

  gate_tt_driver #(.SETTLE_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1),
    .a(a1), .b(b1), .s(s1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_idx(fi1), .obs_tt(obs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign s0 = tt0[{a0, b0}];

  always @(posedge clk) begin
    pipe1[0] <= tt1[{a1, b1}];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign s1 = pipe1[2];

  // Reference: pass iff the gate table equals the expected table, the
  // failing index is the lowest differing bit, done closes 4*(S+1)+1
  // edges after the accepting edge.
  function automatic exp_t model(input logic [3:0] e, input logic [3:0] g,
                                 input int accept, input int settle);
    exp_t r;
    r.pass = (e == g);
    r.fi   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (e[i] != g[i]) r.fi = 2'(i);
    end
    r.obs    = CAP ? g : 4'b0000;
    r.accept = accept;
    r.lat    = 4 * (settle + 1) + 1;
    return r;
  endfunction

  task automatic chk(input string tag, input string what, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s %s: got %0d, want %0d (cycle %0d)", tag, what, act, req, cyc);
    end
  endtask

  task automatic cmp_entry(input string tag, input exp_t e, input logic p,
                           input logic [1:0] f, input logic [3:0] o);
    chk(tag, "latency", cyc + 1 - e.accept, e.lat);
    chk(tag, "pass", int'(p), int'(e.pass));
    chk(tag, "fail_idx", int'(f), int'(e.fi));
    chk(tag, "obs_tt", int'(o), int'(e.obs));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " u0"}, "outputs", int'({a0, b0, busy0, done0, pass0, fi0, obs0}), 0);
    chk({tag, " u1"}, "outputs", int'({a1, b1, busy1, done1, pass1, fi1, obs1}), 0);
  endtask

  task automatic run0(input logic [3:0] e, input logic [3:0] g);
    @(negedge clk);
    tt0    = g;
    exp0   = e;
    start0 = 1'b1;
    last0  = model(e, g, cyc + 1, 1);
    q0.push_back(last0);
    @(negedge clk);
    start0 = 1'b0;
    chk("u0", "busy after start", int'(busy0), 1);
  endtask

  task automatic run1(input logic [3:0] e, input logic [3:0] g);
    @(negedge clk);
    tt1    = g;
    exp1   = e;
    start1 = 1'b1;
    last1  = model(e, g, cyc + 1, 3);
    q1.push_back(last1);
    @(negedge clk);
    start1 = 1'b0;
    chk("u1", "busy after start", int'(busy1), 1);
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("u0", "pending runs", q0.size(), 0);
    repeat (2) @(negedge clk);
    chk("u0", "pass held", int'(pass0), int'(last0.pass));
    chk("u0", "fail_idx held", int'(fi0), int'(last0.fi));
  endtask

  task automatic drain1();
    int n = 0;
    while (q1.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("u1", "pending runs", q1.size(), 0);
    repeat (2) @(negedge clk);
    chk("u1", "pass held", int'(pass1), int'(last1.pass));
    chk("u1", "fail_idx held", int'(fi1), int'(last1.fi));
  endtask

  initial begin
    rst_n  = 1'b1;
    start0 = 1'b0; exp0 = '0; tt0 = '0;
    start1 = 1'b0; exp1 = '0; tt1 = '0;
    vectors = 0;
    miscompares = 0;
    fork
      begin : stim
        int a_t;
        int n;
        logic [3:0] e, g;
        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run0(4'b0111, 4'b0111); drain0();  // NAND gate
        run0(4'b0111, 4'b1000); drain0();  // AND gate
        run0(4'b0111, 4'b0011); drain0();  // NAND broken at idx 2
        run0(4'b0110, 4'b1001); drain0();  // multiple mismatches

        // Extra start while busy must be ignored.
        run0(4'b0110, 4'b0110);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain0();

        // Start held high: new run accepted in the IDLE cycle after DONE.
        @(negedge clk);
        tt0  = 4'b0111;
        exp0 = 4'b0111;
        a_t  = cyc + 1;
        for (int k = 0; k < 3; k++) begin
          last0 = model(4'b0111, 4'b0111, a_t + k * (4 * 2 + 2), 1);
          q0.push_back(last0);
        end
        start0 = 1'b1;
        while (cyc < a_t + 21) @(negedge clk);
        start0 = 1'b0;
        drain0();

        // Reset during SAMPLE of idx 1: no done, outputs cleared at once.
        @(negedge clk);
        tt0 = 4'b0111; exp0 = 4'b0111; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while ({a0, b0} != 2'b01 && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("u0", "reached idx1", int'({a0, b0}), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("mid-run reset");
        repeat (2) @(negedge clk);
        check_zero("held reset");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run0(4'b0111, 4'b0111); drain0();

        for (int i = 0; i < 20; i++) begin
          e = 4'($urandom_range(15, 0));
          g = ($urandom_range(1, 0) == 1) ? e : 4'($urandom_range(15, 0));
          run0(e, g);
          drain0();
        end

        run1(4'b0111, 4'b0111); drain1();  // delayed NAND, settle 3
        run1(4'b0111, 4'b1000); drain1();
        for (int i = 0; i < 12; i++) begin
          e = 4'($urandom_range(15, 0));
          g = ($urandom_range(1, 0) == 1) ? e : 4'($urandom_range(15, 0));
          run1(e, g);
          drain1();
        end
        repeat (20) @(negedge clk);
      end
      begin : mon
        exp_t x;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (done0) begin
              if (q0.size() == 0) begin
                chk("u0", "done without run", int'(done0), 0);
              end else begin
                x = q0.pop_front();
                cmp_entry("u0", x, pass0, fi0, obs0);
              end
            end
            if (done1) begin
              if (q1.size() == 0) begin
                chk("u1", "done without run", int'(done1), 0);
              end else begin
                x = q1.pop_front();
                cmp_entry("u1", x, pass1, fi1, obs1);
              end
            end
          end
        end
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
